// File: rtl/rr_packet_arbiter.sv
// Round-robin packet scheduler: grants one show-ahead input FIFO for a whole
// header+LEN packet onto a single output link, then rotates priority.
module rr_packet_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int GW    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       port_enable,
  input  logic [N-1:0]       fifo_ready,
  input  logic [N*WIDTH-1:0] fifo_dout,
  output logic [N-1:0]       fifo_pop,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [GW-1:0]      grant,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [GW-1:0] grant_next;
  logic [7:0]    remaining, remaining_next;
  logic [7:0]    len;
  logic [N-1:0]  requests;
  logic          transfer;
  logic          found;
  int            idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= GW'(N - 1);
      remaining <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      remaining <= remaining_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case/if tree can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    grant_next     = grant;
    remaining_next = remaining;
    fifo_pop       = '0;
    found          = 1'b0;
    idx            = 0;

    out_data  = fifo_dout[int'(grant)*WIDTH +: WIDTH];
    len       = out_data[7:0];
    out_valid = (state != IDLE) && fifo_ready[grant];
    transfer  = out_valid && out_ready;
    out_last  = out_valid && (((state == HEADER) && (len == 8'd0)) ||
                              ((state == BODY) && (remaining == 8'd1)));
    busy      = (state != IDLE);
    requests  = fifo_ready & port_enable;

    case (state)
      IDLE: begin
        // Search starts just after the last grant so priority rotates.
        for (int k = 1; k <= N; k++) begin
          idx = (int'(grant) + k) % N;
          if (!found && requests[idx]) begin
            found      = 1'b1;
            grant_next = GW'(idx);
          end
        end
        if (found) state_next = HEADER;
      end
      HEADER: begin
        if (transfer) begin
          fifo_pop[grant] = 1'b1;
          remaining_next  = len;
          state_next      = (len == 8'd0) ? IDLE : BODY;
        end
      end
      BODY: begin
        if (transfer) begin
          fifo_pop[grant] = 1'b1;
          remaining_next  = remaining - 8'd1;
          if (remaining == 8'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: behavioural show-ahead FIFOs feed the
// arbiter and every observation is compared with hand-computed values.
module tb_rr_packet_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int GW    = 2;
  localparam int DEPTH = 64;

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       port_enable;
  logic [N-1:0]       fifo_ready;
  logic [N*WIDTH-1:0] fifo_dout;
  logic [N-1:0]       fifo_pop;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [GW-1:0]      grant;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem [N][DEPTH];
  int head [N] = '{default: 0};
  int tail [N] = '{default: 0};
  int pops [N] = '{default: 0};
  int base;

  rr_packet_arbiter #(.N(N), .WIDTH(WIDTH), .GW(GW)) dut (
    .clock      (clock),
    .reset      (reset),
    .port_enable(port_enable),
    .fifo_ready (fifo_ready),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fifo_ready[i]              = (head[i] != tail[i]);
      fifo_dout[i*WIDTH +: WIDTH] = mem[i][head[i] % DEPTH];
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_pop[i]) begin
        head[i] <= head[i] + 1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] w);
    mem[i][tail[i] % DEPTH] = w;
    tail[i] = tail[i] + 1;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < DEPTH; j++) mem[i][j] = '0;
    mem[3][0]   = 32'hD3D3_0000;
    reset       = 1'b1;
    port_enable = 4'b1111;
    out_ready   = 1'b1;
    tick();

    // Reset values
    check("rst_grant", 32'(grant), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
    check("rst_data", out_data, 32'hD3D3_0000);
    reset = 1'b0;
    tick();

    // Single LEN=3 packet on input 2
    push(2, 32'hA200_0003); push(2, 32'hA200_0011);
    push(2, 32'hA200_0012); push(2, 32'hA200_0013);
    #1;
    check("t1_pre_busy", 32'(busy), 32'd0);
    check("t1_pre_valid", 32'(out_valid), 32'd0);
    base = pops[2];
    tick();
    check("t1_grant", 32'(grant), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("t1_valid%0d", w), 32'(out_valid), 32'd1);
      check($sformatf("t1_data%0d", w), out_data,
            (w == 0) ? 32'hA200_0003 : 32'hA200_0010 + 32'(w));
      check($sformatf("t1_last%0d", w), 32'(out_last), (w == 3) ? 32'd1 : 32'd0);
      check($sformatf("t1_pop%0d", w), 32'(fifo_pop), 32'b0100);
      tick();
    end
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_popcnt", 32'(pops[2] - base), 32'd4);

    // Saturated LEN=1 load after a fresh reset
    reset = 1'b1;
    #1;
    check("t2_rst_grant", 32'(grant), 32'd3);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      push(i, 32'h5000_0001 | (32'(i) << 16)); push(i, 32'h5000_0100);
      push(i, 32'h5000_0001 | (32'(i) << 16)); push(i, 32'h5000_0200);
    end
    tick();
    for (int p = 0; p < 8; p++) begin
      check($sformatf("t2_grant%0d", p), 32'(grant), 32'(p % 4));
      check($sformatf("t2_hdr_last%0d", p), 32'(out_last), 32'd0);
      tick();
      check($sformatf("t2_body_last%0d", p), 32'(out_last), 32'd1);
      tick();
      check($sformatf("t2_bubble%0d", p), 32'(busy), 32'd0);
      tick();
    end

    // LEN=0 packet on input 1
    push(1, 32'hB100_0000);
    base = pops[1];
    tick();
    check("t3_grant", 32'(grant), 32'd1);
    check("t3_last", 32'(out_last), 32'd1);
    check("t3_pop", 32'(fifo_pop), 32'b0010);
    tick();
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_popcnt", 32'(pops[1] - base), 32'd1);

    // LEN=2 packet with a 5-cycle downstream stall mid-body
    push(0, 32'hC000_0002); push(0, 32'hC000_0021); push(0, 32'hC000_0022);
    base = pops[0];
    tick();
    check("t4_grant", 32'(grant), 32'd0);
    tick();
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t4_stall_data%0d", s), out_data, 32'hC000_0021);
      check($sformatf("t4_stall_pop%0d", s), 32'(fifo_pop), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4_b1_pop", 32'(fifo_pop), 32'b0001);
    check("t4_b1_last", 32'(out_last), 32'd0);
    tick();
    check("t4_b2_data", out_data, 32'hC000_0022);
    check("t4_b2_last", 32'(out_last), 32'd1);
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_popcnt", 32'(pops[0] - base), 32'd3);

    // Granted FIFO empties after the header; input 3 must wait
    push(2, 32'hD200_0002);
    push(3, 32'hE300_0000);
    tick();
    check("t5_grant", 32'(grant), 32'd2);
    tick();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("t5_gap_valid%0d", g), 32'(out_valid), 32'd0);
      check($sformatf("t5_gap_grant%0d", g), 32'(grant), 32'd2);
      check($sformatf("t5_gap_busy%0d", g), 32'(busy), 32'd1);
      tick();
    end
    push(2, 32'hD200_0031); push(2, 32'hD200_0032);
    #1;
    check("t5_b1_data", out_data, 32'hD200_0031);
    check("t5_b1_valid", 32'(out_valid), 32'd1);
    tick();
    check("t5_b2_last", 32'(out_last), 32'd1);
    tick();
    check("t5_idle", 32'(busy), 32'd0);
    tick();
    check("t5_next_grant", 32'(grant), 32'd3);
    check("t5_next_last", 32'(out_last), 32'd1);
    tick();

    // Reset in BODY with remaining=5, then masked rotation
    push(0, 32'hF000_0006);
    for (int b = 1; b <= 6; b++) push(0, 32'hF000_0000 | (32'(b) << 8));
    base = pops[0];
    tick();
    tick();
    tick();
    check("t6_pre_data", out_data, 32'hF000_0200);
    check("t6_pre_pops", 32'(pops[0] - base), 32'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_pop", 32'(fifo_pop), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd3);
    port_enable = 4'b1011;
    push(1, 32'h6100_0000); push(2, 32'h6200_0000); push(3, 32'h6300_0000);
    tick();
    reset = 1'b0;
    check("t6_kept_words", 32'(pops[0] - base), 32'd2);
    tick();
    check("t6_grant0", 32'(grant), 32'd0);
    check("t6_data0", out_data, 32'hF000_0200);
    tick();
    tick();
    check("t6_grant1", 32'(grant), 32'd1);
    tick();
    tick();
    check("t6_grant3", 32'(grant), 32'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_packet_arbiter.md
# rr_packet_arbiter

Round-robin packet scheduler that shares one 32-bit output link among N input FIFOs in the router. Each input FIFO presents a show-ahead word (`dout` valid whenever `ready`) and accepts a `pop`. The arbiter grants one FIFO at a time for a whole packet, forwards the header and the counted payload words, then rotates priority. It sits between the per-input FIFOs and the output port logic.

## Interface
- `N`, 4: number of input FIFOs; allowed range 2..8.
- `WIDTH`, 32: data word width.
- `GW`, 2: grant index width; equals clog2(N).
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `port_enable`  in  N  per-input arbitration enable; 0 masks that input from new grants.
- `fifo_ready`  in  N  per-input "not empty" from each FIFO.
- `fifo_dout`  in  N*WIDTH  head word of each FIFO; input i occupies bits [i*WIDTH +: WIDTH].
- `fifo_pop`  out  N  one-hot pop to the granted FIFO.
- `out_data`  out  WIDTH  forwarded word.
- `out_valid`  out  1  `out_data` is valid this cycle.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_last`  out  1  the current word is the final word of its packet.
- `grant`  out  GW  index of the input currently granted.
- `busy`  out  1  a packet is in progress (state is not IDLE).

## Operation
- Packet format: the header word's bits [7:0] hold LEN, the number of payload words (0..255). The header itself is forwarded. A packet is 1+LEN words.
- States:
  - IDLE: if any `fifo_ready[i] & port_enable[i]`, pick the first such i searching from (`grant`+1) mod N upward with wrap. Register `grant` <= i and go to HEADER. Otherwise stay in IDLE.
  - HEADER: on a transfer, load `remaining` <= LEN. If LEN==0, go to IDLE; else go to BODY.
  - BODY: on a transfer, `remaining` <= `remaining`-1. If `remaining`==1, go to IDLE.
- Output signals (combinational):
  - `out_data` = `fifo_dout` slice[`grant`].
  - `out_valid` = (state != IDLE) & `fifo_ready[grant]`.
- Transfer = `out_valid & out_ready`.
- `fifo_pop[grant]` = transfer. All other pop bits are 0, and all pop bits are 0 in IDLE.
- `out_last` = `out_valid` & ((HEADER & LEN==0) | (BODY & `remaining`==1)).
- `remaining` is 8 bits. It never underflows, because BODY is only entered with `remaining` >= 1.
- Mid-packet conditions do not preempt the grant:
  - If the granted FIFO goes empty mid-packet, `out_valid` drops and the arbiter waits in the current state.
  - Deasserting `port_enable` for the granted input has no effect until the packet completes.
- `out_ready` low holds all state; `out_data` stays equal to the FIFO head.

## Timing
- Reset values:
  - State = IDLE.
  - `grant` = N-1, so port 0 has first priority.
  - `remaining` = 0.
  - `fifo_pop` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0.
  - `out_data` = slice N-1 of `fifo_dout`.
- Grant latency: a request seen in IDLE at edge k gives `busy`=1 and `out_valid` in the cycle after edge k. This is exactly one IDLE cycle per packet.
- Throughput: 1+LEN words in 1+LEN cycles when the FIFO and downstream never stall. There is one bubble between consecutive packets.
- `fifo_pop` is combinational from `out_ready`. The FIFO samples the pop at the same edge that the downstream samples the word.
- Reset asserted mid-packet: abort immediately. No pop is issued, and words of the partial packet remain in the FIFO.
- Simultaneous requests in IDLE: strictly rotating priority. Over a saturated load each enabled input gets one packet per N packets.

## Test plan
- After reset, input 2 alone holds a header with LEN=3 plus 3 payload words:
  - `grant`=2 and `out_valid` go high one cycle after the request.
  - 4 transfers follow, with `out_last` on the 4th only.
  - `fifo_pop[2]` pulses exactly 4 times, then the arbiter returns to IDLE.
- All 4 inputs continuously loaded with LEN=1 packets: grant order 0,1,2,3,0,1 with one IDLE bubble between packets.
- A header with LEN=0 on input 1: single transfer with `out_last`=1 on the header, then IDLE.
- LEN=2 packet with `out_ready` held low for 5 cycles mid-body:
  - `out_data` is stable and no pop is issued while stalled.
  - The packet completes with 3 pops total.
- Granted FIFO runs empty after the header (LEN=2), then the body words arrive 4 cycles later:
  - `out_valid`=0 during the gap and `grant` is unchanged.
  - Input 3, which has `fifo_ready` high, receives no grant until the packet completes.
- Reset asserted during BODY with `remaining`=5: state returns to IDLE in the same cycle, `fifo_pop`=0, and `grant`=N-1. With `port_enable`=4'b1011 and all inputs ready, the next grant is 0, then 1, then 3; input 2 is skipped.
